// File: rtl/rv32_irq_pkg.sv
// Shared definitions for the platform interrupt arbiter: register offsets and gateway states.
package rv32_irq_pkg;

   localparam logic [7:0] IRQ_PENDING   = 8'h00;
   localparam logic [7:0] IRQ_ENABLE    = 8'h04;
   localparam logic [7:0] IRQ_THRESH    = 8'h08;
   localparam logic [7:0] IRQ_CLAIM     = 8'h0C;
   localparam logic [7:0] IRQ_PRIO_BASE = 8'h40;

   typedef enum logic [1:0] {
      GW_IDLE = 2'd0,
      GW_PEND = 2'd1,
      GW_INFL = 2'd2
   } gw_state_e;

endpackage

// File: rtl/rv32_irq_gateway.sv
// Per-source interrupt gateway: latches a request, holds it through claim and
// blocks the source until the ISR completes it.
module rv32_irq_gateway
   import rv32_irq_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic src,
   input  logic claim_hit,
   input  logic complete_hit,
   output logic pending,
   output logic pending_nxt
);

   gw_state_e state_q, state_d;

   always_ff @(posedge clk) begin
      if (rst) state_q <= GW_IDLE;
      else     state_q <= state_d;
   end

   // A completed source passes through IDLE for one cycle before it can re-pend.
   always_comb begin
      state_d = state_q;
      case (state_q)
         GW_IDLE: if (src)          state_d = GW_PEND;
         GW_PEND: if (claim_hit)    state_d = GW_INFL;
         GW_INFL: if (complete_hit) state_d = GW_IDLE;
         default:                   state_d = GW_IDLE;
      endcase
   end

   always_comb begin
      pending     = (state_q == GW_PEND);
      pending_nxt = (state_d == GW_PEND);
   end

endmodule

// File: rtl/rv32_irq_arbiter.sv
// Platform-level interrupt arbiter: gateways, priority/enable/threshold registers,
// claim/complete handshake and a registered external interrupt line.
module rv32_irq_arbiter
   import rv32_irq_pkg::*;
#(
   parameter int N_SRC  = 8,
   parameter int PRIO_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_SRC-1:0]  irq_src,
   input  logic              bus_req,
   input  logic              bus_we,
   input  logic [7:0]        bus_addr,
   input  logic [31:0]       bus_wdata,
   output logic [31:0]       bus_rdata,
   output logic              bus_ready,
   output logic              irq_out
);

   localparam int         ID_W      = $clog2(N_SRC + 1);
   localparam logic [5:0] W_PENDING = IRQ_PENDING[7:2];
   localparam logic [5:0] W_ENABLE  = IRQ_ENABLE[7:2];
   localparam logic [5:0] W_THRESH  = IRQ_THRESH[7:2];
   localparam logic [5:0] W_CLAIM   = IRQ_CLAIM[7:2];
   localparam logic [5:0] W_PRIO    = IRQ_PRIO_BASE[7:2];

   logic [N_SRC-1:0]  enable_q;
   logic [PRIO_W-1:0] thresh_q;
   logic [PRIO_W-1:0] prio_q [N_SRC];
   logic [N_SRC-1:0]  pending, pending_nxt, claim_hit, complete_hit;
   logic [ID_W-1:0]   best_id_q, best_id_d;
   logic [PRIO_W-1:0] best_prio_d;
   logic [5:0]        word;
   logic              rd_acc, wr_acc, claim_acc, complete_acc;
   logic [31:0]       rdata_d;
   logic              unused_addr_lsb;

   assign word            = bus_addr[7:2];
   assign unused_addr_lsb = ^bus_addr[1:0];
   assign rd_acc          = bus_req && !bus_we;
   assign wr_acc          = bus_req &&  bus_we;
   assign claim_acc       = rd_acc && (word == W_CLAIM);
   assign complete_acc    = wr_acc && (word == W_CLAIM);

   // A claim retires the currently registered winner; IDs outside 1..N_SRC match no gateway.
   for (genvar k = 0; k < N_SRC; k++) begin : g_gw
      assign claim_hit[k]    = claim_acc && (best_id_q == ID_W'(k + 1));
      assign complete_hit[k] = complete_acc && (bus_wdata == 32'(k + 1));

      rv32_irq_gateway u_gw (
         .clk          (clk),
         .rst          (rst),
         .src          (irq_src[k]),
         .claim_hit    (claim_hit[k]),
         .complete_hit (complete_hit[k]),
         .pending      (pending[k]),
         .pending_nxt  (pending_nxt[k])
      );
   end

   // Arbitrate over next-cycle pending so a claimed source drops out at the claim edge.
   always_comb begin
      best_id_d   = '0;
      best_prio_d = '0;
      for (int k = 0; k < N_SRC; k++) begin
         if (pending_nxt[k] && enable_q[k] && (prio_q[k] > thresh_q) &&
             (prio_q[k] > best_prio_d)) begin
            best_prio_d = prio_q[k];
            best_id_d   = ID_W'(k + 1);
         end
      end
   end

   always_comb begin
      rdata_d = '0;
      case (word)
         W_PENDING: rdata_d[N_SRC-1:0]  = pending;
         W_ENABLE:  rdata_d[N_SRC-1:0]  = enable_q;
         W_THRESH:  rdata_d[PRIO_W-1:0] = thresh_q;
         W_CLAIM:   rdata_d[ID_W-1:0]   = best_id_q;
         default: begin
            for (int k = 0; k < N_SRC; k++)
               if (word == 6'(W_PRIO + k)) rdata_d[PRIO_W-1:0] = prio_q[k];
         end
      endcase
      if (!rd_acc) rdata_d = '0;
   end

   // Configuration registers
   always_ff @(posedge clk) begin
      if (rst) begin
         enable_q <= '0;
         thresh_q <= '0;
         for (int k = 0; k < N_SRC; k++) prio_q[k] <= '0;
      end else if (wr_acc) begin
         if (word == W_ENABLE) enable_q <= bus_wdata[N_SRC-1:0];
         if (word == W_THRESH) thresh_q <= bus_wdata[PRIO_W-1:0];
         for (int k = 0; k < N_SRC; k++)
            if (word == 6'(W_PRIO + k)) prio_q[k] <= bus_wdata[PRIO_W-1:0];
      end
   end

   // Arbitration result, interrupt line and bus response
   always_ff @(posedge clk) begin
      if (rst) begin
         best_id_q <= '0;
         irq_out   <= 1'b0;
         bus_ready <= 1'b0;
         bus_rdata <= '0;
      end else begin
         best_id_q <= best_id_d;
         irq_out   <= (best_id_q != '0);
         bus_ready <= bus_req;
         bus_rdata <= rdata_d;
      end
   end

endmodule

// File: tb/tb_rv32_irq_arbiter.sv
// Bench for rv32_irq_arbiter: directed register/interrupt scenarios checked against a
// rule-level model every cycle, plus literal expectations for the key results.
module tb_rv32_irq_arbiter;

   localparam int N_SRC  = 8;
   localparam int PRIO_W = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [N_SRC-1:0]  irq_src = '0;
   logic              bus_req = 1'b0;
   logic              bus_we = 1'b0;
   logic [7:0]        bus_addr = '0;
   logic [31:0]       bus_wdata = '0;
   logic [31:0]       bus_rdata;
   logic              bus_ready;
   logic              irq_out;

   int checks = 0;
   int failures = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   rv32_irq_arbiter #(.N_SRC(N_SRC), .PRIO_W(PRIO_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .irq_src   (irq_src),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_rdata (bus_rdata),
      .bus_ready (bus_ready),
      .irq_out   (irq_out)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Rule-level model: pending/in-flight flags per source, config, and output pipeline.
   bit          m_pend [N_SRC];
   bit          m_infl [N_SRC];
   bit          m_en   [N_SRC];
   int          m_pr   [N_SRC];
   int          m_th;
   int          m_best;
   bit          m_irq;
   bit          m_ready;
   logic [31:0] m_rdata;

   function automatic int pick_winner();
      for (int p = (1 << PRIO_W) - 1; p > m_th; p--)
         for (int k = 0; k < N_SRC; k++)
            if (m_pend[k] && m_en[k] && m_pr[k] == p) return k + 1;
      return 0;
   endfunction

   always @(posedge clk) begin
      int          word;
      int          claimed;
      logic [31:0] rd;
      if (rst) begin
         for (int k = 0; k < N_SRC; k++) begin
            m_pend[k] = 0; m_infl[k] = 0; m_en[k] = 0; m_pr[k] = 0;
         end
         m_th = 0; m_best = 0; m_irq = 0; m_ready = 0; m_rdata = '0;
      end else begin
         word = int'(bus_addr[7:2]);
         rd = '0;
         if (bus_req && !bus_we) begin
            if (word == 0)      for (int k = 0; k < N_SRC; k++) rd[k] = m_pend[k];
            else if (word == 1) for (int k = 0; k < N_SRC; k++) rd[k] = m_en[k];
            else if (word == 2) rd = 32'(m_th);
            else if (word == 3) rd = 32'(m_best);
            else if (word >= 16 && word < 16 + N_SRC) rd = 32'(m_pr[word - 16]);
         end
         claimed = (bus_req && !bus_we && word == 3) ? m_best : 0;
         for (int k = 0; k < N_SRC; k++) begin
            if (claimed == k + 1) begin
               m_pend[k] = 0; m_infl[k] = 1;
            end else if (m_infl[k] && bus_req && bus_we && word == 3 && bus_wdata == 32'(k + 1)) begin
               m_infl[k] = 0;
            end else if (!m_pend[k] && !m_infl[k] && irq_src[k]) begin
               m_pend[k] = 1;
            end
         end
         m_irq  = (m_best != 0);
         m_best = pick_winner();
         if (bus_req && bus_we) begin
            if (word == 1) for (int k = 0; k < N_SRC; k++) m_en[k] = bus_wdata[k];
            if (word == 2) m_th = int'(bus_wdata[PRIO_W-1:0]);
            if (word >= 16 && word < 16 + N_SRC) m_pr[word - 16] = int'(bus_wdata[PRIO_W-1:0]);
         end
         m_ready = bus_req;
         m_rdata = rd;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("model_irq_out", {31'd0, irq_out}, {31'd0, m_irq});
         chk("model_bus_ready", {31'd0, bus_ready}, {31'd0, m_ready});
         chk("model_bus_rdata", bus_rdata, m_rdata);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
      bus_req = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
      tick(1);
      bus_req = 1'b0; bus_we = 1'b0;
   endtask

   task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
      bus_req = 1'b1; bus_we = 1'b0; bus_addr = a;
      tick(1);
      d = bus_rdata;
      bus_req = 1'b0;
   endtask

   initial begin
      logic [31:0] d;
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      cmp_en = 1'b1;
      chk("reset_irq_out", {31'd0, irq_out}, 32'd0);
      chk("reset_bus_ready", {31'd0, bus_ready}, 32'd0);
      chk("reset_bus_rdata", bus_rdata, 32'd0);

      // Single source, latency and claim
      bus_wr(8'h48, 32'd5);
      bus_wr(8'h04, 32'h04);
      irq_src[2] = 1'b1;
      tick(1);
      irq_src[2] = 1'b0;
      chk("t1_irq_one_cycle", {31'd0, irq_out}, 32'd0);
      tick(1);
      chk("t1_irq_two_cycles", {31'd0, irq_out}, 32'd1);
      bus_rd(8'h0C, d); chk("t1_claim", d, 32'd3);
      tick(1);
      chk("t1_irq_after_claim", {31'd0, irq_out}, 32'd0);
      bus_rd(8'h04, d); chk("t1_enable_rb", d, 32'h04);
      bus_rd(8'h48, d); chk("t1_prio2_rb", d, 32'd5);
      bus_wr(8'h0C, 32'd3);

      // Priority ordering and index tie-break
      bus_wr(8'h44, 32'd4);
      bus_wr(8'h58, 32'd4);
      bus_wr(8'h4C, 32'd6);
      bus_wr(8'h04, 32'hFF);
      irq_src = 8'b0100_1010;
      tick(1);
      irq_src = '0;
      tick(1);
      bus_rd(8'h0C, d); chk("t2_claim_a", d, 32'd4);
      bus_wr(8'h0C, 32'd4);
      bus_rd(8'h0C, d); chk("t2_claim_b", d, 32'd2);
      bus_wr(8'h0C, 32'd2);
      bus_rd(8'h0C, d); chk("t2_claim_c", d, 32'd7);
      bus_wr(8'h0C, 32'd7);
      bus_rd(8'h0C, d); chk("t2_claim_none", d, 32'd0);

      // Threshold masking
      bus_wr(8'h08, 32'd4);
      bus_wr(8'h40, 32'd4);
      irq_src[0] = 1'b1;
      tick(3);
      chk("t3_masked", {31'd0, irq_out}, 32'd0);
      bus_wr(8'h08, 32'd3);
      chk("t3_wr_plus1", {31'd0, irq_out}, 32'd0);
      tick(1);
      chk("t3_wr_plus2_pre", {31'd0, irq_out}, 32'd0);
      tick(1);
      chk("t3_wr_plus2", {31'd0, irq_out}, 32'd1);

      // No re-pend while in flight
      bus_rd(8'h0C, d); chk("t4_claim", d, 32'd1);
      tick(2);
      bus_rd(8'h00, d); chk("t4_pending_infl", d, 32'd0);
      bus_rd(8'h0C, d); chk("t4_claim_empty", d, 32'd0);
      chk("t4_irq_infl", {31'd0, irq_out}, 32'd0);
      bus_wr(8'h0C, 32'd1);
      chk("t4_irq_at_complete", {31'd0, irq_out}, 32'd0);
      tick(1);
      bus_rd(8'h00, d); chk("t4_repend", d, 32'd1);
      chk("t4_irq_repend", {31'd0, irq_out}, 32'd1);
      irq_src[0] = 1'b0;
      bus_rd(8'h0C, d); chk("t4_claim_again", d, 32'd1);
      bus_wr(8'h0C, 32'd1);

      // Invalid completes and unmapped reads
      bus_wr(8'h50, 32'd6);
      irq_src[4] = 1'b1;
      tick(1);
      irq_src[4] = 1'b0;
      tick(1);
      bus_rd(8'h0C, d); chk("t5_claim", d, 32'd5);
      bus_wr(8'h0C, 32'd9);
      bus_wr(8'h0C, 32'd2);
      bus_wr(8'h0C, 32'd0);
      irq_src[4] = 1'b1;
      tick(2);
      bus_rd(8'h00, d); chk("t5_pending_kept", d, 32'd0);
      chk("t5_irq", {31'd0, irq_out}, 32'd0);
      bus_rd(8'h10, d); chk("t5_unmapped_10", d, 32'd0);
      bus_rd(8'h60, d); chk("t5_unmapped_60", d, 32'd0);
      bus_rd(8'h0C, d); chk("t5_claim_empty", d, 32'd0);
      bus_wr(8'h0C, 32'd5);
      tick(2);
      bus_rd(8'h00, d); chk("t5_repend", d, 32'h10);
      irq_src[4] = 1'b0;

      // Reset while a source is in flight
      bus_wr(8'h54, 32'd7);
      irq_src[5] = 1'b1;
      tick(2);
      bus_rd(8'h0C, d); chk("t6_claim", d, 32'd6);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("t6_rst_irq", {31'd0, irq_out}, 32'd0);
      chk("t6_rst_ready", {31'd0, bus_ready}, 32'd0);
      bus_rd(8'h00, d); chk("t6_pending", d, 32'd0);
      bus_rd(8'h04, d); chk("t6_enable_clr", d, 32'd0);
      bus_wr(8'h54, 32'd7);
      bus_wr(8'h04, 32'h20);
      chk("t6_irq_plus1", {31'd0, irq_out}, 32'd0);
      tick(1);
      chk("t6_irq_plus1b", {31'd0, irq_out}, 32'd0);
      tick(1);
      chk("t6_irq_plus2", {31'd0, irq_out}, 32'd1);
      bus_rd(8'h0C, d); chk("t6_claim_after", d, 32'd6);
      irq_src = '0;
      tick(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
